// File: rtl/apb_reg_slave.sv
// APB3/APB4 completer owning a bank of NUM_REGS word-wide registers, with wait-state
// insertion, decode-error reporting, byte-lane strobes, read-only status words and write pulses.
module apb_reg_slave #(
    parameter int                     ADDR_W      = 8,
    parameter int                     DATA_W      = 32,
    parameter int                     NUM_REGS    = 16,
    parameter int                     WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_W-1:0]      RESET_VAL   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             paddr,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [DATA_W-1:0]             pwdata,
    input  logic [DATA_W/8-1:0]           pstrb,
    output logic [DATA_W-1:0]             prdata,
    output logic                          pready,
    output logic                          pslverr,
    input  logic [NUM_REGS*DATA_W-1:0]    sts_in,
    output logic [NUM_REGS*DATA_W-1:0]    reg_q,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [3:0]            cnt_r, cnt_nxt_s;
    logic                  latch_s, commit_s;

    logic [IDX_W-1:0]      idx_r;
    logic                  wr_r;
    logic                  err_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [STRB_W-1:0]     strb_r;

    logic [IDX_W-1:0]      idx_sel_s;
    logic                  wr_sel_s;
    logic                  err_sel_s;
    logic                  pready_nxt_s;
    logic [DATA_W-1:0]     rdata_nxt_s;
    logic [NUM_REGS-1:0]   wr_pulse_nxt_s;

    logic [DATA_W-1:0]     regs_r [NUM_REGS];
    logic                  pready_r;
    logic                  pslverr_r;
    logic [DATA_W-1:0]     prdata_r;
    logic [NUM_REGS-1:0]   wr_pulse_r;

    function automatic logic is_ro(input logic [IDX_W-1:0] idx);
        logic ro;
        ro = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ro = (idx == IDX_W'(i)) ? RO_MASK[i] : ro;
        end
        return ro;
    endfunction

    function automatic logic decode_err(input logic [ADDR_W-1:0] addr, input logic wr);
        logic [IDX_W-1:0] idx;
        idx = addr[ADDR_W-1:2];
        return (addr[1:0] != 2'b00) || (int'(idx) >= NUM_REGS) || (wr && is_ro(idx));
    endfunction

    // Transfer FSM: setup/access sequencing, wait countdown, commit and abort.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (psel && !penable) begin
                    state_nxt_s = ST_ACCESS;
                    cnt_nxt_s   = 4'(WAIT_CYCLES);
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (penable && (cnt_r == 4'd0)) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (penable) begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Response for the cycle ahead; with zero wait states it is built from the live setup phase.
    always_comb begin
        idx_sel_s    = latch_s ? paddr[ADDR_W-1:2] : idx_r;
        wr_sel_s     = latch_s ? pwrite : wr_r;
        err_sel_s    = latch_s ? decode_err(paddr, pwrite) : err_r;
        pready_nxt_s = (state_nxt_s == ST_ACCESS) && (cnt_nxt_s == 4'd0);
        rdata_nxt_s  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rdata_nxt_s = (pready_nxt_s && !wr_sel_s && !err_sel_s && (idx_sel_s == IDX_W'(i)))
                        ? (RO_MASK[i] ? sts_in[i*DATA_W +: DATA_W] : regs_r[i])
                        : rdata_nxt_s;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse_nxt_s[i] = commit_s && wr_r && !err_r && (idx_r == IDX_W'(i));
        end
    end

    // FSM state, latched transfer attributes and registered APB response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            idx_r      <= '0;
            wr_r       <= 1'b0;
            err_r      <= 1'b0;
            wdata_r    <= '0;
            strb_r     <= '0;
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
            prdata_r   <= '0;
            wr_pulse_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            if (latch_s) begin
                idx_r   <= paddr[ADDR_W-1:2];
                wr_r    <= pwrite;
                err_r   <= decode_err(paddr, pwrite);
                wdata_r <= pwdata;
                strb_r  <= pstrb;
            end
            pready_r   <= pready_nxt_s;
            pslverr_r  <= pready_nxt_s && err_sel_s;
            prdata_r   <= rdata_nxt_s;
            wr_pulse_r <= wr_pulse_nxt_s;
        end
    end

    // Register bank: byte-lane merge on a committed, error-free write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_pulse_nxt_s[i] && strb_r[b]) begin
                        regs_r[i][8*b +: 8] <= wdata_r[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read-only slots expose zero on reg_q; their value lives on sts_in.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
        assign reg_q[gi*DATA_W +: DATA_W] = RO_MASK[gi] ? {DATA_W{1'b0}} : regs_r[gi];
    end

    assign pready   = pready_r;
    assign pslverr  = pslverr_r;
    assign prdata   = prdata_r;
    assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: a zero-wait instance with RO reg 3 and a
// three-wait-state instance with a non-zero reset value, driven by directed transfers.
module tb_apb_reg_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [7:0]    paddr   [2];
    logic          psel    [2];
    logic          penable [2];
    logic          pwrite  [2];
    logic [31:0]   pwdata  [2];
    logic [3:0]    pstrb   [2];
    logic [31:0]   prdata  [2];
    logic          pready  [2];
    logic          pslverr [2];
    logic [511:0]  sts_in  [2];
    logic [511:0]  reg_q   [2];
    logic [15:0]   wr_pulse[2];

    apb_reg_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0),
                    .RO_MASK(16'h0008), .RESET_VAL(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .sts_in(sts_in[0]), .reg_q(reg_q[0]),
        .wr_pulse(wr_pulse[0]));

    apb_reg_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(3),
                    .RO_MASK(16'h0000), .RESET_VAL(32'h0000_A5A5)) dut3 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .sts_in(sts_in[1]), .reg_q(reg_q[1]),
        .wr_pulse(wr_pulse[1]));

    typedef struct {
        int          dut;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rq(input int d, input int i);
        return reg_q[d][i*32 +: 32];
    endfunction

    // Monitor: every completing transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && psel[d] && penable[d] && pready[d]) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: dut index %0d completed a transfer with nothing expected", d);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk({e.name, "_dut"},   64'(d),          64'(e.dut));
                    chk({e.name, "_err"},   64'(pslverr[d]), 64'(e.err));
                    chk({e.name, "_rdata"}, 64'(prdata[d]),  64'(e.rdata));
                end
            end
        end
    end

    // Called at #1 after a posedge; returns #1 after the completing posedge.
    task automatic xfer(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] erd, input logic eerr,
                        input bit b2b, input string name, input int hold_idx,
                        input logic [31:0] hold_val, output int waits);
        exp_t e;
        bit   done;
        e.dut = d; e.err = eerr; e.rdata = erd; e.name = name;
        sb_q.push_back(e);
        paddr[d] = a; pwrite[d] = w; pwdata[d] = wd; pstrb[d] = st;
        psel[d] = 1'b1; penable[d] = 1'b0;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (pready[d] === 1'b1) begin
                done = 1'b1;
            end else begin
                waits++;
                if (hold_idx >= 0) chk({name, "_hold"}, 64'(rq(d, hold_idx)), 64'(hold_val));
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: pready low for %0d cycles, required completion", name, waits);
            void'(sb_q.pop_back());
        end
        @(posedge clk); #1;
        if (!b2b) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            paddr[d] = 8'h00; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            pwdata[d] = 32'h0; pstrb[d] = 4'h0;
        end
        for (int i = 0; i < 16; i++) sts_in[0][i*32 +: 32] = {16'hC0DE, 16'(i)};
        sts_in[0][3*32 +: 32] = 32'hCAFE_0003;
        sts_in[1] = 512'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready0",   64'(pready[0]),   64'h0);
        chk("rst_pready3",   64'(pready[1]),   64'h0);
        chk("rst_pslverr0",  64'(pslverr[0]),  64'h0);
        chk("rst_prdata0",   64'(prdata[0]),   64'h0);
        chk("rst_wr_pulse0", 64'(wr_pulse[0]), 64'h0);
        chk("rst_wr_pulse3", 64'(wr_pulse[1]), 64'h0);
        chk("rst_regq0_r1",  64'(rq(0, 1)),    64'h0);
        chk("rst_regq3_r2",  64'(rq(1, 2)),    64'h0000_A5A5);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a waited access, with pready already high.
        xfer(1, 8'h08, 1'b1, 32'h0000_0011, 4'hF, 32'h0, 1'b0, 1'b0, "t1_pre", -1, 32'h0, w);
        chk("t1_pre_reg",   64'(rq(1, 2)),    64'h11);
        chk("t1_pre_pulse", 64'(wr_pulse[1]), 64'h0004);
        paddr[1] = 8'h08; pwrite[1] = 1'b1; pwdata[1] = 32'h0000_0099; pstrb[1] = 4'hF;
        psel[1] = 1'b1; penable[1] = 1'b0;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_pready_before_rst", 64'(pready[1]), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t1_pready_at_rst", 64'(pready[1]), 64'h0);
        chk("t1_reg_at_rst",    64'(rq(1, 2)),  64'h0000_A5A5);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        chk("t1_pulse_in_rst", 64'(wr_pulse[1]), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 8'h08, 1'b0, 32'h0, 4'hF, 32'h0000_A5A5, 1'b0, 1'b0, "t1_rd", -1, 32'h0, w);
        chk("t1_rd_waits", 64'(w), 64'd3);

        // Zero-wait write and readback.
        xfer(0, 8'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, "t2_wr", -1, 32'h0, w);
        chk("t2_waits", 64'(w),           64'd0);
        chk("t2_pulse", 64'(wr_pulse[0]), 64'h0002);
        chk("t2_reg",   64'(rq(0, 1)),    64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t2_pulse_gone", 64'(wr_pulse[0]), 64'h0);
        xfer(0, 8'h04, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, "t2_rd", -1, 32'h0, w);

        // Three wait states; the register must hold its old value until the commit edge.
        xfer(1, 8'h08, 1'b1, 32'h0000_0005, 4'hF, 32'h0, 1'b0, 1'b0, "t3_wr", 2, 32'h0000_A5A5, w);
        chk("t3_waits", 64'(w),           64'd3);
        chk("t3_reg",   64'(rq(1, 2)),    64'h5);
        chk("t3_pulse", 64'(wr_pulse[1]), 64'h0004);

        // Byte strobes.
        xfer(0, 8'h04, 1'b1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b0, "t4_strb", -1, 32'h0, w);
        chk("t4_strb_reg", 64'(rq(0, 1)), 64'hDE22_BE44);
        xfer(0, 8'h04, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b0, "t4_nostrb", -1, 32'h0, w);
        chk("t4_nostrb_reg",   64'(rq(0, 1)),    64'hDE22_BE44);
        chk("t4_nostrb_pulse", 64'(wr_pulse[0]), 64'h0002);

        // Decode errors and read-only status.
        xfer(0, 8'h41, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, "t5_misalign_rd", -1, 32'h0, w);
        xfer(0, 8'h05, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, "t5_misalign_wr", -1, 32'h0, w);
        chk("t5_misalign_wr_reg",   64'(rq(0, 1)),    64'hDE22_BE44);
        chk("t5_misalign_wr_pulse", 64'(wr_pulse[0]), 64'h0);
        xfer(0, 8'h40, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b0, "t5_range_wr", -1, 32'h0, w);
        chk("t5_range_pulse", 64'(wr_pulse[0]), 64'h0);
        xfer(0, 8'h40, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, "t5_range_rd", -1, 32'h0, w);
        xfer(0, 8'h0C, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 1'b0, "t5_ro_wr", -1, 32'h0, w);
        chk("t5_ro_pulse", 64'(wr_pulse[0]), 64'h0);
        xfer(0, 8'h0C, 1'b0, 32'h0, 4'hF, 32'hCAFE_0003, 1'b0, 1'b0, "t5_ro_rd", -1, 32'h0, w);
        xfer(0, 8'h08, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, "t5_rw_rd", -1, 32'h0, w);

        // Back-to-back write then read with no idle cycle.
        xfer(0, 8'h00, 1'b1, 32'hA1B2_C3D4, 4'hF, 32'h0, 1'b0, 1'b1, "t6_b2b_wr", -1, 32'h0, w);
        chk("t6_b2b_pulse", 64'(wr_pulse[0]), 64'h0001);
        xfer(0, 8'h00, 1'b0, 32'h0, 4'hF, 32'hA1B2_C3D4, 1'b0, 1'b0, "t6_b2b_rd", -1, 32'h0, w);
        chk("t6_b2b_rd_waits", 64'(w), 64'd0);

        // psel withdrawn mid-wait.
        paddr[1] = 8'h08; pwrite[1] = 1'b1; pwdata[1] = 32'h0000_0077; pstrb[1] = 4'hF;
        psel[1] = 1'b1; penable[1] = 1'b0;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        chk("t6_abort_pready", 64'(pready[1]), 64'h0);
        @(posedge clk); #1;
        chk("t6_abort_reg",   64'(rq(1, 2)),    64'h5);
        chk("t6_abort_pulse", 64'(wr_pulse[1]), 64'h0);
        xfer(1, 8'h08, 1'b0, 32'h0, 4'hF, 32'h0000_0005, 1'b0, 1'b0, "t6_after_abort", -1, 32'h0, w);
        chk("t6_after_abort_waits", 64'(w), 64'd3);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
